mem_access_unit: RTL and testbench

Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage, converts the byte address to a word index, and drives the memory's write/read/address/data/stage pins. Captures the registered read data and returns a single-cycle response to the write-back stage. Sits between the pipeline datapath and the data memory.

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory initiator: one load/store at a time, single-cycle response
// Optional MEM_BYTE_OPS_EN builds byte loads (lb/lbu) and read-modify-write byte stores.
module mem_access_unit #(
  parameter int MEM_WORDS    = 128,
  parameter int ADDR_W       = 8,
  parameter int ACCESS_STAGE = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              memWrite,
  output logic              memRead,
  output logic [ADDR_W-1:0] memaddress,
  output logic [31:0]       invalue,
  input  logic [31:0]       outvalue,
  output logic [2:0]        stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_ERR,
    S_RESP
`ifdef MEM_BYTE_OPS_EN
    , S_RMW_RD,
    S_RMW_WAIT
`endif
  } state_t;

  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);
  localparam logic [2:0]  LP_STAGE = 3'(ACCESS_STAGE);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_memaddress;
  logic [31:0]         r_invalue;
  logic [31:0]         r_rdata;

  logic [ADDR_W-1:0]   w_index;
  logic                w_upper_err;
  logic                w_range_err;
  logic                w_align_err;
  logic                w_byte_err;
  logic                w_req_err;
  logic                w_accept;
  logic [31:0]         w_load_data;

  assign w_index     = req_addr[ADDR_W+1:2];
  assign w_upper_err = |req_addr[31:ADDR_W+2];
  assign w_range_err = 32'(w_index) >= LP_WORDS;
  assign w_align_err = !req_byte && (req_addr[1:0] != 2'b00);
  assign w_req_err   = w_upper_err || w_range_err || w_align_err || w_byte_err;
  assign w_accept    = req_valid && req_ready;

  assign memaddress  = r_memaddress;
  assign invalue     = r_invalue;
  assign resp_rdata  = r_rdata;

`ifdef MEM_BYTE_OPS_EN
  logic        r_byte;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [7:0]  r_wbyte;
  logic [7:0]  w_lane_byte;
  logic [31:0] w_merged;

  assign w_byte_err  = 1'b0;
  assign w_lane_byte = outvalue[{r_lane, 3'b000} +: 8];
  assign w_load_data = !r_byte     ? outvalue :
                       r_unsigned ? {24'h000000, w_lane_byte} :
                                    {{24{w_lane_byte[7]}}, w_lane_byte};

  always_comb begin
    w_merged = outvalue;
    w_merged[{r_lane, 3'b000} +: 8] = r_wbyte;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_byte     <= 1'b0;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wbyte    <= 8'h00;
    end else if (w_accept) begin
      r_byte     <= req_byte;
      r_unsigned <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_wbyte    <= req_wdata[7:0];
    end
  end
`else
  // Byte requests are rejected, so the sign/zero-extension select is never consulted.
  logic w_unused_ok;
  assign w_unused_ok = req_unsigned;
  assign w_byte_err  = req_byte;
  assign w_load_data = outvalue;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    busy         = 1'b1;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    stage        = 3'd0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (w_req_err)       w_next_state = S_ERR;
          else if (!req_write) w_next_state = S_RD;
`ifdef MEM_BYTE_OPS_EN
          else if (req_byte)   w_next_state = S_RMW_RD;
`endif
          else                 w_next_state = S_WR;
        end
      end
      S_RD: begin
        memRead      = 1'b1;
        stage        = LP_STAGE;
        w_next_state = S_WAIT;
      end
      S_WAIT: w_next_state = S_RESP;
      S_WR: begin
        memWrite     = 1'b1;
        stage        = LP_STAGE;
        w_next_state = S_RESP;
      end
      S_ERR: begin
        resp_valid   = 1'b1;
        resp_err     = 1'b1;
        w_next_state = S_IDLE;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
`ifdef MEM_BYTE_OPS_EN
      S_RMW_RD: begin
        memRead      = 1'b1;
        stage        = LP_STAGE;
        w_next_state = S_RMW_WAIT;
      end
      S_RMW_WAIT: w_next_state = S_WR;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // memaddress is only moved by good requests so it keeps its last value while idle or on errors.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_memaddress <= '0;
      r_invalue    <= 32'h0;
      r_rdata      <= 32'h0;
    end else begin
      if (w_accept) begin
        r_rdata <= 32'h0;
        if (!w_req_err) begin
          r_memaddress <= w_index;
          if (req_write && !req_byte) begin
            r_invalue <= req_wdata;
          end
        end
      end
      if (r_state == S_WAIT) begin
        r_rdata <= w_load_data;
      end
`ifdef MEM_BYTE_OPS_EN
      if (r_state == S_RMW_WAIT) begin
        r_invalue <= w_merged;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a transaction-level model
module tb_mem_access_unit;
  localparam int MEM_WORDS = 128;
  localparam int ADDR_W    = 8;
`ifdef MEM_BYTE_OPS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic              clock;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  logic              memWrite;
  logic              memRead;
  logic [ADDR_W-1:0] memaddress;
  logic [31:0]       invalue;
  logic [31:0]       outvalue;
  logic [2:0]        stage;

  int n_checks = 0;
  int n_errs   = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .ACCESS_STAGE(3)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .memWrite(memWrite), .memRead(memRead),
    .memaddress(memaddress), .invalue(invalue), .outvalue(outvalue), .stage(stage)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory with a registered read port.
  logic [31:0] env_mem [0:255];
  always @(posedge clock) begin
    if (memWrite) env_mem[memaddress] <= invalue;
    if (memRead)  outvalue <= env_mem[memaddress];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: memory contents as the program should see them.
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  function automatic bit m_err(input logic b, input logic [31:0] a);
    return ((a >> (ADDR_W + 2)) != 0) || (((a >> 2) % (1 << ADDR_W)) >= MEM_WORDS) ||
           (!b && (a % 4) != 0) || (b && !BYTE_EN);
  endfunction

  function automatic int m_lat(input logic w, input logic b, input logic [31:0] a);
    if (m_err(b, a)) return 1;
    if (!w) return 3;
    return b ? 4 : 2;
  endfunction

  function automatic logic [31:0] m_rdata(input logic w, input logic b, input logic u, input logic [31:0] a);
    logic [31:0] word, byt;
    if (m_err(b, a) || w) return 32'h0;
    word = ref_mem[(a >> 2) % MEM_WORDS];
    if (!b) return word;
    byt = (word >> (8 * (a % 4))) & 32'hFF;
    if (!u && byt >= 128) byt = byt | 32'hFFFFFF00;
    return byt;
  endfunction

  function automatic logic [31:0] m_store(input logic b, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] sh;
    if (!b) return wd;
    sh = 8 * (a % 4);
    return (ref_mem[(a >> 2) % MEM_WORDS] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
  endfunction

  bit          chk_en = 0;
  bit          m_busy = 0;
  bit          acc_pending = 0;
  int          age, n_rd, n_wr;
  int          e_lat, e_rd, e_wr;
  bit          e_err;
  logic [31:0] e_rdata, e_wdata;
  logic [7:0]  e_idx;

  // Compare process: inputs settle at posedge+1, everything is sampled at the negedge.
  always @(negedge clock) begin
    if (chk_en) begin
      if (acc_pending) begin
        m_busy = 1; age = 1; acc_pending = 0; n_rd = 0; n_wr = 0;
      end else if (m_busy) begin
        age++;
      end
      chk("req_ready", req_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("rd_wr_excl", memRead && memWrite, 0);
      chk("stage", stage, (memRead || memWrite) ? 3 : 0);
      if (!m_busy) chk("idle_no_access", memRead || memWrite, 0);
      if (memRead) begin
        n_rd++;
        chk("rd_addr", memaddress, e_idx);
      end
      if (memWrite) begin
        n_wr++;
        chk("wr_addr", memaddress, e_idx);
        chk("wr_data", invalue, e_wdata);
      end
      chk("resp_valid", resp_valid, m_busy && age == e_lat);
      if (m_busy && age == e_lat) begin
        chk("resp_err", resp_err, e_err);
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("n_reads", n_rd, e_rd);
        chk("n_writes", n_wr, e_wr);
        m_busy = 0;
      end
      if (!resetn) begin
        m_busy = 0; acc_pending = 0;
      end else if (req_valid && req_ready) begin
        e_err   = m_err(req_byte, req_addr);
        e_lat   = m_lat(req_write, req_byte, req_addr);
        e_rdata = m_rdata(req_write, req_byte, req_unsigned, req_addr);
        e_rd    = (!e_err && (!req_write || req_byte)) ? 1 : 0;
        e_wr    = (!e_err && req_write) ? 1 : 0;
        e_idx   = req_addr[ADDR_W+1:2];
        if (!e_err && req_write) begin
          e_wdata = m_store(req_byte, req_addr, req_wdata);
          ref_mem[(req_addr >> 2) % MEM_WORDS] = e_wdata;
        end
        acc_pending = 1;
      end
    end
  end

  task automatic do_req(input logic w, input logic b, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input bit wait_done);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", req_ready, 1);
      return;
    end
    req_write = w; req_byte = b; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~wd; req_unsigned = ~u;
    if (wait_done) begin
      n = 0;
      while ((m_busy || acc_pending) && n < 20) begin
        @(posedge clock); #1; n++;
      end
      chk("done_timeout", m_busy || acc_pending, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_memaddress", memaddress, 0);
    chk("rst_invalue", invalue, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_stage", stage, 0);
    resetn = 1'b1;
    chk_en = 1;

    chk("pin_lat_sw", m_lat(1, 0, 32'h10), 2);
    do_req(1, 0, 0, 32'h10, 32'hDEADBEEF, 0);
    chk("pin_ld_10", m_rdata(0, 0, 0, 32'h10), 32'hDEADBEEF);
    chk("pin_lat_lw", m_lat(0, 0, 32'h10), 3);
    do_req(0, 0, 0, 32'h10, 32'h0, 0);

    chk("pin_err_mis", m_err(0, 32'h12), 1);
    chk("pin_err_rng", m_err(0, 32'h200), 1);
    chk("pin_err_hi", m_err(0, 32'h80000000), 1);
    chk("pin_ok_1fc", m_err(0, 32'h1FC), 0);
    chk("pin_lat_err", m_lat(0, 0, 32'h12), 1);
    do_req(0, 0, 0, 32'h12, 32'h0, 0);
    do_req(0, 0, 0, 32'h200, 32'h0, 0);
    do_req(0, 0, 0, 32'h80000000, 32'h0, 0);
    do_req(1, 0, 0, 32'h13, 32'h12345678, 0);
    do_req(1, 0, 0, 32'h1FC, 32'hCAFEF00D, 0);
    do_req(0, 0, 0, 32'h1FC, 32'h0, 0);

    do_req(1, 0, 0, 32'h20, 32'h11223344, 0);
`ifdef MEM_BYTE_OPS_EN
    chk("pin_sb_merge", m_store(1, 32'h21, 32'h000000AA), 32'h1122AA44);
    chk("pin_lat_sb", m_lat(1, 1, 32'h21), 4);
    do_req(1, 1, 0, 32'h21, 32'h555555AA, 0);
    chk("pin_lb", m_rdata(0, 1, 0, 32'h21), 32'hFFFFFFAA);
    chk("pin_lbu", m_rdata(0, 1, 1, 32'h21), 32'h000000AA);
    do_req(0, 1, 0, 32'h21, 32'h0, 0);
    do_req(0, 1, 1, 32'h21, 32'h0, 0);
    do_req(0, 1, 0, 32'h23, 32'h0, 0);
    do_req(0, 1, 0, 32'h20, 32'h0, 0);
    do_req(0, 0, 0, 32'h20, 32'h0, 1);
    chk("mem_word_20", env_mem[8], 32'h1122AA44);
`else
    chk("pin_lb_err", m_err(1, 32'h21), 1);
    do_req(0, 1, 0, 32'h21, 32'h0, 0);
    do_req(1, 1, 0, 32'h21, 32'h000000AA, 1);
    chk("mem_word_20", env_mem[8], 32'h11223344);
`endif

    do_req(0, 0, 0, 32'h10, 32'h0, 0);
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_resp", resp_valid, 0);
    do_req(0, 0, 0, 32'h10, 32'h0, 1);
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
